// File: rtl/pf_ddr_iod_lane_dly_ctrl_if.sv
// Command handshake between DDR PHY training logic and the IOD lane
// delay controller.
interface pf_ddr_iod_lane_dly_ctrl_if #(
   parameter int LANE_W = 1,
   parameter int TAP_W  = 8
);
   logic              CMD_VALID;
   logic              CMD_READY;
   logic [LANE_W-1:0] CMD_LANE;
   logic [1:0]        CMD_OP;
   logic [TAP_W-1:0]  CMD_COUNT;
   logic              CMD_DONE;

   modport master (
      output CMD_VALID, CMD_LANE, CMD_OP, CMD_COUNT,
      input  CMD_READY, CMD_DONE
   );

   modport slave (
      input  CMD_VALID, CMD_LANE, CMD_OP, CMD_COUNT,
      output CMD_READY, CMD_DONE
   );
endinterface

// File: rtl/pf_ddr_iod_lane_dly_ctrl.sv
// Fabric-side controller for TX-only DDR IOD lanes: registers TX/OE
// nibbles and sequences LOAD/MOVE/DIRECTION for one lane at a time.
module pf_ddr_iod_lane_dly_ctrl #(
   parameter int NUM_LANES     = 2,
   parameter int TAP_W         = 8,
   parameter int TAP_MAX       = 255,
   parameter int TAP_INIT      = 1,
   parameter int SETTLE_CYCLES = 4,
   parameter int PARK_ON_MOVE  = 1,
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                       FAB_CLK,
   input  logic                       TX_SYNC_RST,
   input  logic [4*NUM_LANES-1:0]     TX_DATA_IN,
   input  logic [4*NUM_LANES-1:0]     OE_DATA_IN,
   output logic [4*NUM_LANES-1:0]     TX_DATA_OUT,
   output logic [4*NUM_LANES-1:0]     OE_DATA_OUT,
   pf_ddr_iod_lane_dly_ctrl_if.slave  cmd,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
   output logic [TAP_W*NUM_LANES-1:0] TAP_VAL,
   output logic [NUM_LANES-1:0]       ERR_OOR,
   input  logic                       ERR_CLR
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MOVE,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [LANE_W-1:0]    r_lane;
   logic                 r_is_load;
   logic [TAP_W-1:0]     r_rem;
   logic [3:0]           r_cnt;
   logic [TAP_W-1:0]     r_tap [NUM_LANES];
   logic [NUM_LANES-1:0] r_dir;
   logic [NUM_LANES-1:0] r_err;
   logic [4*NUM_LANES-1:0] r_tx;
   logic [4*NUM_LANES-1:0] r_oe;

   logic                 w_ready;
   logic                 w_accept;
   logic                 w_lane_ok;
   logic [TAP_W-1:0]     w_tap_cur;
   logic [TAP_W:0]       w_sum;
   logic                 w_is_move;
   logic                 w_rng_bad;
   logic                 w_go_move;
   logic                 w_last;
   logic                 w_oor;
   logic                 w_step_ok;
   logic                 w_busy;
   logic [NUM_LANES-1:0] w_oh_cmd;
   logic [NUM_LANES-1:0] w_oh_act;
   logic [NUM_LANES-1:0] w_err_set;
   logic [NUM_LANES-1:0] w_park_lane;
   logic [4*NUM_LANES-1:0] w_park;

   assign w_ready   = (r_state == S_IDLE) & ~TX_SYNC_RST;
   assign w_accept  = cmd.CMD_VALID & w_ready;
   assign w_lane_ok = 32'(cmd.CMD_LANE) < NUM_LANES;
   assign w_tap_cur = w_lane_ok ? r_tap[cmd.CMD_LANE] : '0;
   assign w_sum     = {1'b0, w_tap_cur} + {1'b0, cmd.CMD_COUNT};
   assign w_is_move = (cmd.CMD_OP == OP_INC) | (cmd.CMD_OP == OP_DEC);

   // Range is checked on the full requested walk, before any strobe.
   assign w_rng_bad = (cmd.CMD_OP == OP_INC)
                    ? (w_sum > (TAP_W+1)'(TAP_MAX))
                    : (cmd.CMD_COUNT > w_tap_cur);
   assign w_go_move = w_is_move & (cmd.CMD_COUNT != '0) & ~w_rng_bad;

   assign w_last    = (r_cnt == 4'(SETTLE_CYCLES - 1));
   assign w_oor     = DELAY_LINE_OUT_OF_RANGE[r_lane];
   assign w_step_ok = (r_state == S_SETTLE) & w_last & ~w_oor;
   assign w_busy    = (r_state == S_LOAD) | (r_state == S_MOVE)
                    | (r_state == S_SETTLE);

   assign w_oh_cmd  = NUM_LANES'(1'b1) << cmd.CMD_LANE;
   assign w_oh_act  = NUM_LANES'(1'b1) << r_lane;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_lane_ok)
                  w_next = S_DONE;
               else if (cmd.CMD_OP == OP_LOAD)
                  w_next = S_LOAD;
               else if (w_go_move)
                  w_next = S_MOVE;
               else
                  w_next = S_DONE;
            end
         end
         S_LOAD:   w_next = S_SETTLE;
         S_MOVE:   w_next = S_SETTLE;
         S_SETTLE: begin
            if (w_last) begin
               if (w_oor || r_is_load || r_rem == TAP_W'(1))
                  w_next = S_DONE;
               else
                  w_next = S_MOVE;
            end
         end
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_err_set = '0;
      if (w_accept && w_lane_ok && w_is_move
          && cmd.CMD_COUNT != '0 && w_rng_bad)
         w_err_set = w_oh_cmd;
      if (r_state == S_SETTLE && w_last && w_oor)
         w_err_set = w_err_set | w_oh_act;
   end

   // OE parks from the cycle after accept up to and including DONE.
   always_comb begin
      w_park_lane = '0;
      if (PARK_ON_MOVE != 0) begin
         if (w_accept && w_lane_ok)
            w_park_lane = w_oh_cmd;
         else if (w_busy)
            w_park_lane = w_oh_act;
      end
      w_park = '0;
      for (int i = 0; i < NUM_LANES; i++)
         w_park[4*i +: 4] = {4{w_park_lane[i]}};
   end

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         r_lane    <= '0;
         r_is_load <= 1'b0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_dir     <= '0;
         r_err     <= '0;
         r_tx      <= '0;
         r_oe      <= '0;
         for (int i = 0; i < NUM_LANES; i++)
            r_tap[i] <= TAP_W'(TAP_INIT);
      end else begin
         r_tx  <= TX_DATA_IN;
         r_oe  <= OE_DATA_IN & ~w_park;
         r_err <= (ERR_CLR ? '0 : r_err) | w_err_set;

         if (r_state == S_LOAD || r_state == S_MOVE)
            r_cnt <= '0;
         else if (r_state == S_SETTLE)
            r_cnt <= r_cnt + 4'd1;

         if (w_accept) begin
            r_lane    <= cmd.CMD_LANE;
            r_is_load <= (cmd.CMD_OP == OP_LOAD);
            r_rem     <= cmd.CMD_COUNT;
            r_dir     <= (r_dir & ~w_oh_cmd)
                       | (w_oh_cmd & {NUM_LANES{cmd.CMD_OP == OP_INC}});
         end

         if (r_state == S_LOAD)
            r_tap[r_lane] <= TAP_W'(TAP_INIT);

         if (w_step_ok && !r_is_load) begin
            r_rem <= r_rem - TAP_W'(1);
            if (r_dir[r_lane])
               r_tap[r_lane] <= r_tap[r_lane] + TAP_W'(1);
            else
               r_tap[r_lane] <= r_tap[r_lane] - TAP_W'(1);
         end

         if (r_state == S_DONE)
            r_dir <= r_dir & ~w_oh_act;
      end
   end

   assign cmd.CMD_READY        = w_ready;
   assign cmd.CMD_DONE         = (r_state == S_DONE);
   assign DELAY_LINE_LOAD      = (r_state == S_LOAD) ? w_oh_act : '0;
   assign DELAY_LINE_MOVE      = (r_state == S_MOVE) ? w_oh_act : '0;
   assign DELAY_LINE_DIRECTION = r_dir;
   assign ERR_OOR              = r_err;
   assign TX_DATA_OUT          = r_tx;
   assign OE_DATA_OUT          = r_oe;

   always_comb begin
      TAP_VAL = '0;
      for (int i = 0; i < NUM_LANES; i++)
         TAP_VAL[TAP_W*i +: TAP_W] = r_tap[i];
   end

endmodule

// File: doc/pf_ddr_iod_lane_dly_ctrl.md
# pf_ddr_iod_lane_dly_ctrl

Parametrised fabric-side controller for a group of DDR PHY output IOD lanes (address/command/bank-group style, TX-only). It registers the per-lane 4:1 TX and OE nibbles toward the IODs and sequences the dynamic delay-line controls (LOAD/MOVE/DIRECTION) for any one lane from a simple command interface. It tracks the tap position of every lane, range-checks requests, and honours the IOD out-of-range flag. It sits between the DDR PHY training/fabric logic and the PF_IOD lane wrappers, in the FAB_CLK domain.

## Interface
- NUM_LANES, 2, number of IOD lanes controlled (1..32)
- TAP_W, 8, width of tap counters and CMD_COUNT
- TAP_MAX, 255, highest legal tap value
- TAP_INIT, 1, tap value after reset and after a LOAD (static configured delay)
- SETTLE_CYCLES, 4, idle cycles after each LOAD/MOVE strobe before the next action (1..15)
- PARK_ON_MOVE, 1, when 1 force the active lane's OE nibble to 0 while its delay is changing
- FAB_CLK  in  1  fabric clock; all logic rising-edge
- TX_SYNC_RST  in  1  reset, synchronous, active-high
- TX_DATA_IN  in  4*NUM_LANES  per-lane TX nibble, lane i at [4i+3:4i]
- OE_DATA_IN  in  4*NUM_LANES  per-lane OE nibble, same packing
- TX_DATA_OUT  out  4*NUM_LANES  registered TX nibbles to IODs
- OE_DATA_OUT  out  4*NUM_LANES  registered (possibly parked) OE nibbles
- CMD_VALID  in  1  command request
- CMD_READY  out  1  controller can accept a command
- CMD_LANE  in  max(1,clog2(NUM_LANES))  target lane
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 NOP
- CMD_COUNT  in  TAP_W  number of tap steps for INC/DEC
- DELAY_LINE_LOAD  out  NUM_LANES  one-cycle load strobe per lane
- DELAY_LINE_MOVE  out  NUM_LANES  one-cycle move strobe per lane
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment, held for whole command
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  IOD range flag per lane
- TAP_VAL  out  TAP_W*NUM_LANES  current tap per lane
- CMD_DONE  out  1  one-cycle completion pulse
- ERR_OOR  out  NUM_LANES  sticky range error per lane
- ERR_CLR  in  1  clears all ERR_OOR bits

## Operation
- Data path: TX_DATA_OUT/OE_DATA_OUT = inputs delayed 1 cycle. If PARK_ON_MOVE=1, the active lane's OE nibble is 0 from the cycle after accept through the CMD_DONE cycle inclusive; other lanes are unaffected.
- FSM states: IDLE, LOAD, MOVE, SETTLE, DONE. CMD_READY=1 only in IDLE.
- IDLE, on CMD_VALID&CMD_READY: latch lane, op, count; DIRECTION[lane] <= (op==INC).
  - LOAD -> LOAD. INC/DEC with count>0 that passes range check -> MOVE.
  - NOP, count==0, CMD_LANE>=NUM_LANES -> DONE, no strobes.
  - Range fail (INC: tap+count>TAP_MAX; DEC: count>tap; sum computed at TAP_W+1 bits) -> set ERR_OOR[lane], DONE, no strobes.
- LOAD: DELAY_LINE_LOAD[lane]=1 for one cycle; tap <= TAP_INIT; -> SETTLE.
- MOVE: DELAY_LINE_MOVE[lane]=1 for one cycle; -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles. On the last cycle sample DELAY_LINE_OUT_OF_RANGE[lane]:
  - If 1: set ERR_OOR[lane], tap not updated, abort -> DONE.
  - Else after a move: tap ±1, remaining--, remaining==0 -> DONE, else -> MOVE.
  - After a load -> DONE.
- DONE: CMD_DONE=1 one cycle; DIRECTION[lane] <= 0; -> IDLE.
- ERR_CLR clears all sticky bits; a set in the same cycle wins for that lane.

## Timing
- Reset values: all strobes 0, DIRECTION 0, CMD_READY 0 during reset then 1, CMD_DONE 0, ERR_OOR 0, TX/OE_DATA_OUT 0, every TAP_VAL = TAP_INIT, FSM IDLE.
- Reset mid-command: abort at the next edge, no CMD_DONE, tap counts return to TAP_INIT.
- Accept at cycle N, S=SETTLE_CYCLES:
  - LOAD: strobe N+1, CMD_DONE N+S+2.
  - INC/DEC k steps: MOVE strobes at N+1+j(S+1) for j=0..k-1, CMD_DONE N+1+k(S+1).
  - Rejected/NOP/invalid lane: CMD_DONE N+1.
  - OOR abort: CMD_DONE one cycle after the sampling SETTLE cycle.
- TAP_VAL updates the cycle after the final SETTLE cycle of each successful step.
- At most one strobe of any kind is active per cycle across all lanes.

## Test plan
- Reset, then INC lane 1 count 3, S=4 -> MOVE[1] at N+1, N+6, N+11; DIRECTION[1]=1 throughout; CMD_DONE N+16; TAP_VAL[1]=4; lane 0 untouched.
- DEC lane 0 count 2 (tap 1) -> no strobes, ERR_OOR[0]=1, CMD_DONE N+1; ERR_CLR -> ERR_OOR=0.
- INC lane 0 count 5, force OUT_OF_RANGE[0]=1 during the 2nd SETTLE -> 2 MOVE strobes, TAP_VAL[0]=2, ERR_OOR[0]=1, early CMD_DONE.
- LOAD lane 1 after INC to 40 -> LOAD[1] at N+1, TAP_VAL[1]=1, CMD_DONE N+6.
- PARK_ON_MOVE=1, OE_DATA_IN all 1s during INC on lane 0 -> lane 0 OE_DATA_OUT=0 through CMD_DONE, lane 1 OE=4'hF; TX data 1-cycle delayed throughout.
- Assert TX_SYNC_RST mid-INC -> strobes 0 next cycle, no CMD_DONE, TAP_VAL=TAP_INIT, CMD_READY=1 after release.
